// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//
// Pipeline interlock controller for the five-stage core. Sits beside the
// decode stage and sequences the decode/issue boundary:
//   - load-use hazard detection against the DEC register read ports
//   - structural hazard on the multi-cycle multiplier
//   - wrong-path squash on taken branches (resolved in EX) and jumps (DEC)
//
// Optional feature macro: HAZARD_STATS_EN
//   defined   : StallCount / FlushCount are free-running 32-bit event
//               counters (wrap from 0xFFFFFFFF to 0).
//   undefined : no counter flops are built; both outputs are tied to zero.
//
// Parameters
//   MUL_CYCLES   multiplier occupancy in cycles after issue (legal 2..15)
//
// Ports
//   Clock        in   core clock, rising edge
//   nReset       in   asynchronous active-low reset
//   DecRsAddr    in   rs field of the DEC instruction
//   DecRtAddr    in   rt field of the DEC instruction
//   DecUsesRs    in   DEC instruction reads rs
//   DecUsesRt    in   DEC instruction reads rt
//   DecMULOp     in   DEC instruction is a multiplier op
//   ExMemRead    in   EX instruction is a load
//   ExRAddr      in   destination register of the EX instruction
//   BranchTaken  in   branch resolved taken in EX this cycle
//   DecJump      in   jump decoded in DEC this cycle
//   StallPC      out  hold the PC
//   StallIFDEC   out  hold the IF/DEC register
//   BubbleEX     out  load a NOP into DEC/EX
//   FlushIFDEC   out  load a NOP into IF/DEC
//   MulBusy      out  multiplier occupied
//   MulDone      out  one-cycle pulse in the final busy cycle
//   StallCount   out  stall-cycle counter
//   FlushCount   out  flush-event counter
// ---------------------------------------------------------------------------
module hazard_unit #(
   parameter int MUL_CYCLES = 4
) (
   input  logic        Clock,
   input  logic        nReset,
   input  logic [4:0]  DecRsAddr,
   input  logic [4:0]  DecRtAddr,
   input  logic        DecUsesRs,
   input  logic        DecUsesRt,
   input  logic        DecMULOp,
   input  logic        ExMemRead,
   input  logic [4:0]  ExRAddr,
   input  logic        BranchTaken,
   input  logic        DecJump,
   output logic        StallPC,
   output logic        StallIFDEC,
   output logic        BubbleEX,
   output logic        FlushIFDEC,
   output logic        MulBusy,
   output logic        MulDone,
   output logic [31:0] StallCount,
   output logic [31:0] FlushCount
);

   typedef enum logic {
      IDLE     = 1'b0,
      MUL_BUSY = 1'b1
   } state_t;

   localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);

   logic [3:0] mul_cnt_reg;
   logic [3:0] mul_cnt_next;
   state_t     state;
   logic       load_use;
   logic       mul_haz;
   logic       stall;
   logic       flush;
   logic       mul_issue;

   // The FSM state is just a view of the occupancy counter.
   assign state = (mul_cnt_reg != 4'd0) ? MUL_BUSY : IDLE;

   // -----------------------------------------------------------------------
   // State register: the multiplier occupancy down-counter.
   // -----------------------------------------------------------------------
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         mul_cnt_reg <= 4'd0;
      end else begin
         mul_cnt_reg <= mul_cnt_next;
      end
   end

   // -----------------------------------------------------------------------
   // Hazard detection, next-state and outputs.
   // -----------------------------------------------------------------------
   always_comb begin
      load_use     = 1'b0;
      mul_haz      = 1'b0;
      stall        = 1'b0;
      flush        = 1'b0;
      mul_issue    = 1'b0;
      mul_cnt_next = mul_cnt_reg;
      StallPC      = 1'b0;
      StallIFDEC   = 1'b0;
      BubbleEX     = 1'b0;
      FlushIFDEC   = 1'b0;
      MulBusy      = 1'b0;
      MulDone      = 1'b0;

      // r0 is hard-wired zero, so a load targeting it never creates a hazard.
      load_use = ExMemRead && (ExRAddr != 5'd0) &&
                 ((DecUsesRs && (DecRsAddr == ExRAddr)) ||
                  (DecUsesRt && (DecRtAddr == ExRAddr)));

      // A MUL waiting while the counter sits at 1 may issue: the unit frees
      // up at the coming edge, giving back-to-back MULs without a gap.
      mul_haz = DecMULOp && (mul_cnt_reg > 4'd1);

      // A taken branch kills the DEC instruction, so stalling it is moot.
      stall = (load_use || mul_haz) && !BranchTaken;

      // Branch beats stall beats jump.
      flush = BranchTaken || (DecJump && !stall);

      StallPC    = stall;
      StallIFDEC = stall;
      BubbleEX   = stall || BranchTaken;
      FlushIFDEC = flush;

      // A MUL already in flight keeps counting down through a branch flush;
      // only a MUL still sitting in DEC is prevented from issuing.
      mul_issue = DecMULOp && !stall && !BranchTaken;

      case (state)
         IDLE: begin
            if (mul_issue) begin
               mul_cnt_next = MUL_LOAD;
            end
         end
         MUL_BUSY: begin
            MulBusy = 1'b1;
            MulDone = (mul_cnt_reg == 4'd1);
            if (mul_issue) begin
               mul_cnt_next = MUL_LOAD;
            end else begin
               mul_cnt_next = mul_cnt_reg - 4'd1;
            end
         end
         default: begin
            mul_cnt_next = 4'd0;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // Optional event counters.
   // -----------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_count_reg;
   logic [31:0] flush_count_reg;

   // Natural 32-bit overflow provides the wrap to zero.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         stall_count_reg <= 32'd0;
         flush_count_reg <= 32'd0;
      end else begin
         if (stall) begin
            stall_count_reg <= stall_count_reg + 32'd1;
         end
         if (flush) begin
            flush_count_reg <= flush_count_reg + 32'd1;
         end
      end
   end

   assign StallCount = stall_count_reg;
   assign FlushCount = flush_count_reg;
`else
   assign StallCount = 32'd0;
   assign FlushCount = 32'd0;
`endif

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline interlock controller for the five-stage core. It sits beside the decode stage and sequences the decode/issue boundary. It detects load-use hazards against the register file read ports, enforces the multi-cycle multiplier's structural hazard, and squashes wrong-path instructions on taken branches and jumps. It drives PC hold, IF/DEC register hold and flush, and EX bubble insertion.

## Interface
- MUL_CYCLES, 4: multiplier occupancy in cycles after issue; legal range 2–15.
- Clock  input  1  core clock; all state updates on rising edge.
- nReset  input  1  asynchronous, active-low reset.
- DecRsAddr  input  5  rs field of the instruction in DEC.
- DecRtAddr  input  5  rt field of the instruction in DEC.
- DecUsesRs  input  1  the DEC instruction reads rs.
- DecUsesRt  input  1  the DEC instruction reads rt.
- DecMULOp  input  1  the DEC instruction is a multiplier op.
- ExMemRead  input  1  the EX instruction is a load.
- ExRAddr  input  5  destination register of the EX instruction.
- BranchTaken  input  1  branch resolved taken in EX this cycle.
- DecJump  input  1  jump decoded in DEC this cycle.
- StallPC  output  1  hold the PC.
- StallIFDEC  output  1  hold the IF/DEC pipeline register.
- BubbleEX  output  1  load a NOP into the DEC/EX register.
- FlushIFDEC  output  1  load a NOP into the IF/DEC register.
- MulBusy  output  1  multiplier occupied.
- MulDone  output  1  one-cycle pulse in the final busy cycle.
- StallCount  output  32  stall-cycle counter (see Configuration).
- FlushCount  output  32  flush-event counter (see Configuration).

## Operation
- State: 4-bit down-counter MulCnt. State name is IDLE when MulCnt==0 and MUL_BUSY when MulCnt!=0.
- Load-use condition: ExMemRead & ExRAddr!=0 & ((DecUsesRs & DecRsAddr==ExRAddr) | (DecUsesRt & DecRtAddr==ExRAddr)).
  - Register 0 never hazards.
- MUL structural condition: DecMULOp & MulCnt>1.
  - A MUL waiting at MulCnt==1 is allowed to issue, so back-to-back MULs are possible.
- Stall = (loadUse | mulHaz) & ~BranchTaken. When Stall is set: StallPC=1, StallIFDEC=1, BubbleEX=1.
- Branch flush: BranchTaken=1 gives FlushIFDEC=1 and BubbleEX=1. The DEC and IF instructions are killed; there is no delay slot. StallPC=0, because the PC loads the target.
- Jump flush: DecJump=1 and no Stall and no BranchTaken gives FlushIFDEC=1. The DEC jump itself proceeds.
- Priority: BranchTaken beats Stall beats DecJump.
- MUL issue: DecMULOp & ~Stall & ~BranchTaken loads MulCnt with MUL_CYCLES at the next edge.
- Otherwise, when MulCnt!=0, MulCnt decrements by 1 each cycle.
- A MUL already issued is never cancelled by a branch flush.
- MulBusy = MulCnt!=0. MulDone = MulCnt==1.
- All outputs are combinational from state and inputs, except counter state.

## Timing
- Reset: MulCnt=0, StallCount=0, FlushCount=0.
  - With all inputs low, every output is 0.
- Reset asserted mid-MUL: MulCnt clears immediately (asynchronously). MulBusy and MulDone drop without a MulDone pulse.
- Load-use stall lasts exactly 1 cycle. The next cycle the load has left EX, so the condition clears.
- MUL issued at edge t: MulBusy is high for cycles t+1 … t+MUL_CYCLES. MulDone is high in cycle t+MUL_CYCLES.
- MUL waiting in DEC behind a busy MUL: stalled while MulCnt>1, issues in the MulDone cycle, and MulCnt reloads with no idle gap.
- Load-use and MUL hazard in the same cycle: a single stall; the signals are OR'd.
- Output latency: hazards detected in cycle n are signalled in cycle n (0-cycle latency).

## Configuration
- HAZARD_STATS_EN defined:
  - StallCount increments each cycle Stall=1.
  - FlushCount increments each cycle FlushIFDEC=1.
  - Both counters wrap from 0xFFFFFFFF to 0.
- HAZARD_STATS_EN undefined: no counter flops are built, and StallCount and FlushCount are tied to 32'd0.

## Test plan
- Load-use: ExMemRead=1, ExRAddr=5, DecUsesRs=1, DecRsAddr=5 -> StallPC=StallIFDEC=BubbleEX=1 for one cycle. Repeating with ExRAddr=0 -> no stall.
- MUL occupancy with MUL_CYCLES=4: issue MUL at cycle 0 and hold a second MUL in DEC -> MulBusy in cycles 1–4, stall in cycles 1–3, MulDone in cycle 4, second MUL issues in cycle 4, MulBusy stays high in cycle 5.
- Branch vs stall: load-use condition and BranchTaken=1 in the same cycle -> FlushIFDEC=1, BubbleEX=1, StallPC=0.
- Jump: DecJump=1, no hazard -> FlushIFDEC=1, BubbleEX=0. DecJump=1 with a load-use hazard -> stall only, and the flush follows the cycle after.
- Reset mid-op: nReset low at cycle 2 of a MUL -> MulBusy=0 immediately and no MulDone pulse; after release, a MUL issues normally.
- Stats, with HAZARD_STATS_EN defined: 3 stalls and 2 flushes -> StallCount=3, FlushCount=2. Preloading 0xFFFFFFFF and adding one stall -> StallCount=0.
